// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - control bundle type, opcode/ALU constants and field-position helpers
package decode_stage_pkg;

  localparam int DEF_INSTR_LEN   = 32;
  localparam int DEF_XLEN        = 32;
  localparam int DEF_OPCODE_SIZE = 5;
  localparam int DEF_REG_ADDR_W  = 4;
  localparam int DEF_IMM_W       = 15;

  localparam int ALU_OP_SIZE = 4;

  typedef enum logic [ALU_OP_SIZE-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_ORR = 4'd3,
    ALU_NOR = 4'd4,
    ALU_XOR = 4'd5,
    ALU_LSL = 4'd6,
    ALU_LSR = 4'd7,
    ALU_LT  = 4'd8
  } alu_op_e;

  typedef struct packed {
    logic    reg_wr_en;
    logic    mem_en;
    logic    mem_rw;
    logic    sel_valb;
    logic    sel_wrdata;
    logic    sel_destreg;
    logic    is_branch;
    alu_op_e alu_op;
  } control_t;

  // Opcodes are held zero-extended to 32 bits so any OPCODE_SIZE up to 32 compares cleanly.
  localparam logic [31:0] OP_NOP  = 32'd0;
  localparam logic [31:0] OP_ADD  = 32'd1;
  localparam logic [31:0] OP_SUB  = 32'd2;
  localparam logic [31:0] OP_AND  = 32'd3;
  localparam logic [31:0] OP_ORR  = 32'd4;
  localparam logic [31:0] OP_NOR  = 32'd5;
  localparam logic [31:0] OP_XOR  = 32'd6;
  localparam logic [31:0] OP_LSL  = 32'd7;
  localparam logic [31:0] OP_LSR  = 32'd8;
  localparam logic [31:0] OP_ADDI = 32'd9;
  localparam logic [31:0] OP_SUBI = 32'd10;
  localparam logic [31:0] OP_LDW  = 32'd11;
  localparam logic [31:0] OP_LDB  = 32'd12;
  localparam logic [31:0] OP_STW  = 32'd13;
  localparam logic [31:0] OP_STB  = 32'd14;
  localparam logic [31:0] OP_BNE  = 32'd15;
  localparam logic [31:0] OP_BST  = 32'd16;
  localparam logic [31:0] OP_BLT  = 32'd17;
  localparam logic [31:0] OP_MOV  = 32'd18;

  // idx 0 = rd, 1 = rs1, 2 = rs2; fields sit MSB-first directly below the opcode.
  function automatic int regFieldLsb(input int instrLen, input int opcodeSize,
                                     input int regAddrW, input int idx);
    return instrLen - opcodeSize - (idx + 1) * regAddrW;
  endfunction

  localparam int DEF_OPC_LSB = DEF_INSTR_LEN - DEF_OPCODE_SIZE;
  localparam int DEF_RD_LSB  = regFieldLsb(DEF_INSTR_LEN, DEF_OPCODE_SIZE, DEF_REG_ADDR_W, 0);
  localparam int DEF_RS1_LSB = regFieldLsb(DEF_INSTR_LEN, DEF_OPCODE_SIZE, DEF_REG_ADDR_W, 1);
  localparam int DEF_RS2_LSB = regFieldLsb(DEF_INSTR_LEN, DEF_OPCODE_SIZE, DEF_REG_ADDR_W, 2);

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode to control bundle, illegal flag and rs2-usage flag
module ctrl_decode
  import decode_stage_pkg::*;
#(
  parameter int OPCODE_SIZE = DEF_OPCODE_SIZE
) (
  input  logic [OPCODE_SIZE-1:0] opcode,
  output control_t               ctrl,
  output logic                   illegal,
  output logic                   usesRs2
);

  logic [31:0] opWide;
  assign opWide = 32'(opcode);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    usesRs2 = 1'b0;
    case (opWide)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_NOR, OP_XOR, OP_LSL, OP_LSR: begin
        ctrl.reg_wr_en = 1'b1;
        usesRs2        = 1'b1;
        case (opWide)
          OP_SUB:  ctrl.alu_op = ALU_SUB;
          OP_AND:  ctrl.alu_op = ALU_AND;
          OP_ORR:  ctrl.alu_op = ALU_ORR;
          OP_NOR:  ctrl.alu_op = ALU_NOR;
          OP_XOR:  ctrl.alu_op = ALU_XOR;
          OP_LSL:  ctrl.alu_op = ALU_LSL;
          OP_LSR:  ctrl.alu_op = ALU_LSR;
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      OP_ADDI, OP_SUBI: begin
        ctrl.reg_wr_en   = 1'b1;
        ctrl.sel_valb    = 1'b1;
        ctrl.sel_destreg = 1'b1;
        ctrl.alu_op      = (opWide == OP_SUBI) ? ALU_SUB : ALU_ADD;
      end
      OP_LDW, OP_LDB: begin
        ctrl.reg_wr_en   = 1'b1;
        ctrl.mem_en      = 1'b1;
        ctrl.sel_valb    = 1'b1;
        ctrl.sel_wrdata  = 1'b1;
        ctrl.sel_destreg = 1'b1;
      end
      OP_STW, OP_STB: begin
        ctrl.mem_en      = 1'b1;
        ctrl.mem_rw      = 1'b1;
        ctrl.sel_valb    = 1'b1;
        ctrl.sel_destreg = 1'b1;
        usesRs2          = 1'b1;
      end
      OP_BNE, OP_BST: begin
        ctrl.is_branch = 1'b1;
        ctrl.alu_op    = ALU_XOR;
      end
      OP_BLT: begin
        ctrl.is_branch = 1'b1;
        ctrl.alu_op    = ALU_LT;
      end
      OP_MOV: begin
        ctrl.reg_wr_en = 1'b1;
        ctrl.alu_op    = ALU_ORR;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with valid/ready, load-use bubble and flush
// DECODE_SKID_EN adds a 1-entry skid buffer and a registered in_ready.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int INSTR_LEN   = DEF_INSTR_LEN,
  parameter int XLEN        = DEF_XLEN,
  parameter int OPCODE_SIZE = DEF_OPCODE_SIZE,
  parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int IMM_W       = DEF_IMM_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_LEN-1:0]  instr,
  input  logic [XLEN-1:0]       pc_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output control_t              ctrl,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [REG_ADDR_W-1:0] rs1,
  output logic [REG_ADDR_W-1:0] rs2,
  output logic [XLEN-1:0]       imm,
  output logic [XLEN-1:0]       pc_out,
  output logic                  illegal
);

  localparam int OPC_LSB = INSTR_LEN - OPCODE_SIZE;
  localparam int RD_LSB  = regFieldLsb(INSTR_LEN, OPCODE_SIZE, REG_ADDR_W, 0);
  localparam int RS1_LSB = regFieldLsb(INSTR_LEN, OPCODE_SIZE, REG_ADDR_W, 1);
  localparam int RS2_LSB = regFieldLsb(INSTR_LEN, OPCODE_SIZE, REG_ADDR_W, 2);

  logic [INSTR_LEN-1:0]   srcInstr;
  logic [XLEN-1:0]        srcPc;
  logic [OPCODE_SIZE-1:0] srcOpcode;
  logic [REG_ADDR_W-1:0]  srcRd, srcRs1, srcRs2;
  logic [XLEN-1:0]        srcImm;
  logic                   srcIsMov;
  control_t               decCtrl;
  logic                   decIllegal, decUsesRs2;
  logic                   heldIsLoad, hazard, canLoad, loadOut;

  assign srcOpcode = srcInstr[OPC_LSB +: OPCODE_SIZE];
  assign srcRd     = srcInstr[RD_LSB  +: REG_ADDR_W];
  assign srcRs1    = srcInstr[RS1_LSB +: REG_ADDR_W];
  assign srcRs2    = srcInstr[RS2_LSB +: REG_ADDR_W];
  assign srcImm    = {{(XLEN-IMM_W){srcInstr[IMM_W-1]}}, srcInstr[IMM_W-1:0]};
  assign srcIsMov  = (32'(srcOpcode) == OP_MOV);

  ctrl_decode #(.OPCODE_SIZE(OPCODE_SIZE)) u_ctrl_decode (
    .opcode  (srcOpcode),
    .ctrl    (decCtrl),
    .illegal (decIllegal),
    .usesRs2 (decUsesRs2)
  );

  // r0 never carries a load result, so a load into r0 cannot create a dependency.
  assign heldIsLoad = out_valid && ctrl.mem_en && !ctrl.mem_rw && (rd != '0);
  assign hazard     = heldIsLoad && ((srcRs1 == rd) || (decUsesRs2 && (srcRs2 == rd)));
  assign canLoad    = (!out_valid || out_ready) && !hazard && !flush;

`ifdef DECODE_SKID_EN
  logic                 skidFull;
  logic [INSTR_LEN-1:0] skidInstr;
  logic [XLEN-1:0]      skidPc;

  assign srcInstr = skidFull ? skidInstr : instr;
  assign srcPc    = skidFull ? skidPc : pc_in;
  assign loadOut  = (skidFull || in_valid) && canLoad;
  assign in_ready = !skidFull;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skidFull  <= 1'b0;
      skidInstr <= '0;
      skidPc    <= '0;
    end else if (flush) begin
      skidFull <= 1'b0;
    end else if (skidFull) begin
      if (canLoad) skidFull <= 1'b0;
    end else if (in_valid && !canLoad) begin
      skidFull  <= 1'b1;
      skidInstr <= instr;
      skidPc    <= pc_in;
    end
  end
`else
  assign srcInstr = instr;
  assign srcPc    = pc_in;
  assign loadOut  = in_valid && canLoad;
  assign in_ready = canLoad;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ctrl      <= '0;
      rd        <= '0;
      rs1       <= '0;
      rs2       <= '0;
      imm       <= '0;
      pc_out    <= '0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (loadOut) begin
      out_valid <= 1'b1;
      ctrl      <= decCtrl;
      rd        <= srcRd;
      rs1       <= srcRs1;
      rs2       <= srcIsMov ? '0 : srcRs2;
      imm       <= srcImm;
      pc_out    <= srcPc;
      illegal   <= decIllegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard testbench for decode_stage
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [31:0] instr, pc_in, imm, pc_out;
  logic [3:0]  rd, rs1, rs2;
  control_t    ctrl;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc_in(pc_in),
    .out_valid(out_valid), .out_ready(out_ready), .ctrl(ctrl),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .pc_out(pc_out), .illegal(illegal)
  );

  typedef struct packed {
    logic [6:0]  flags;
    logic [3:0]  alu;
    logic [3:0]  rd, rs1, rs2;
    logic [31:0] imm, pc;
    logic        ill;
  } exp_t;

  exp_t expQ[$];
  int   tests = 0, failures = 0;
  bit   logEn = 0;
  bit   vlog[$];

  function automatic logic [31:0] mk(input logic [31:0] op, input logic [3:0] d,
                                     input logic [3:0] s1, input logic [3:0] s2,
                                     input logic [14:0] im);
    return {op[4:0], d, s1, s2, im};
  endfunction

  // flags = {reg_wr_en, mem_en, mem_rw, sel_valb, sel_wrdata, sel_destreg, is_branch}
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [31:0] op;
    op    = {27'd0, ins[31:27]};
    e     = '0;
    e.rd  = ins[26:23];
    e.rs1 = ins[22:19];
    e.rs2 = ins[18:15];
    e.imm = {{17{ins[14]}}, ins[14:0]};
    e.pc  = pc;
    e.alu = 4'(ALU_ADD);
    case (op)
      OP_NOP: ;
      OP_ADD: e.flags = 7'b1000000;
      OP_SUB: begin e.flags = 7'b1000000; e.alu = 4'(ALU_SUB); end
      OP_AND: begin e.flags = 7'b1000000; e.alu = 4'(ALU_AND); end
      OP_ORR: begin e.flags = 7'b1000000; e.alu = 4'(ALU_ORR); end
      OP_NOR: begin e.flags = 7'b1000000; e.alu = 4'(ALU_NOR); end
      OP_XOR: begin e.flags = 7'b1000000; e.alu = 4'(ALU_XOR); end
      OP_LSL: begin e.flags = 7'b1000000; e.alu = 4'(ALU_LSL); end
      OP_LSR: begin e.flags = 7'b1000000; e.alu = 4'(ALU_LSR); end
      OP_ADDI: e.flags = 7'b1001010;
      OP_SUBI: begin e.flags = 7'b1001010; e.alu = 4'(ALU_SUB); end
      OP_LDW, OP_LDB: e.flags = 7'b1101110;
      OP_STW, OP_STB: e.flags = 7'b0111010;
      OP_BNE, OP_BST: begin e.flags = 7'b0000001; e.alu = 4'(ALU_XOR); end
      OP_BLT: begin e.flags = 7'b0000001; e.alu = 4'(ALU_LT); end
      OP_MOV: begin e.flags = 7'b1000000; e.alu = 4'(ALU_ORR); e.rs2 = 4'd0; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e, got;
    if (logEn) vlog.push_back(out_valid);
    if (rst_n && out_valid && out_ready) begin
      tests++;
      got = {ctrl.reg_wr_en, ctrl.mem_en, ctrl.mem_rw, ctrl.sel_valb, ctrl.sel_wrdata,
             ctrl.sel_destreg, ctrl.is_branch, 4'(ctrl.alu_op), rd, rs1, rs2, imm, pc_out, illegal};
      if (expQ.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got=%h required=none", got);
      end else begin
        e = expQ.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL sb_bundle pc=%h got=%h required=%h", e.pc, got, e);
        end
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] pc, output int stalls);
    stalls   = 0;
    in_valid = 1'b1;
    instr    = ins;
    pc_in    = pc;
    @(negedge clk);
    while (!in_ready && stalls < 50) begin
      @(negedge clk);
      stalls++;
    end
    if (!in_ready) begin
      tests++; failures++;
      $display("FAIL send_timeout pc=%h got=in_ready_low required=accept", pc);
    end else begin
      expQ.push_back(model(ins, pc));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int s;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; pc_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || ctrl !== '0 || rd !== 0 || rs1 !== 0 || rs2 !== 0 ||
        imm !== 0 || pc_out !== 0 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=v%b c%h rd%h imm%h pc%h required=all_zero", out_valid, ctrl, rd, imm, pc_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(mk(OP_ADD, 1, 2, 3, 0), 32'h40, s);
    tests++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL pre_reset_valid got=%b required=1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || ctrl !== '0) begin
      failures++; $display("FAIL reset_async got=v%b c%h required=v0 c0", out_valid, ctrl);
    end
    expQ.delete();
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(mk(OP_SUB, 2, 3, 4, 15'h10), 32'h44, s);
    tests++;
    if (out_valid !== 1'b1 || rd !== 4'd2) begin
      failures++; $display("FAIL first_after_reset got=v%b rd%h required=v1 rd2", out_valid, rd);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    int s;
    out_ready = 1'b1;
    send(mk(OP_ADD, 3, 1, 2, 0), 32'h100, s);
    tests++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL b2b_first_valid got=%b required=1", out_valid);
    end
    send(mk(OP_ADDI, 4, 3, 0, 15'h7FFF), 32'h104, s);
    tests++;
    if (out_valid !== 1'b1 || s != 0) begin
      failures++; $display("FAIL b2b_second_valid got=v%b stalls%0d required=v1 stalls0", out_valid, s);
    end
    tests++;
    if (imm !== 32'hFFFF_FFFF || ctrl.sel_valb !== 1'b1) begin
      failures++; $display("FAIL b2b_addi_imm got=%h sel_valb=%b required=ffffffff 1", imm, ctrl.sel_valb);
    end
    idle(2);
  endtask

  task automatic load_use(input logic [3:0] ldRd, input int wantBubbles, input string name);
    int s, first, last, zeros;
    out_ready = 1'b1;
    vlog.delete();
    logEn = 1'b1;
    send(mk(OP_LDW, ldRd, 1, 0, 15'd4), 32'h200, s);
    send(mk(OP_ADD, 6, ldRd, 2, 0), 32'h204, s);
    idle(2);
    logEn = 1'b0;
    first = -1; last = -1; zeros = 0;
    foreach (vlog[i]) if (vlog[i]) begin if (first < 0) first = i; last = i; end
    for (int i = first + 1; i < last; i++) if (!vlog[i]) zeros++;
    tests++;
    if (first < 0 || zeros != wantBubbles) begin
      failures++; $display("FAIL %s got=%0d bubbles required=%0d", name, zeros, wantBubbles);
    end
  endtask

  task automatic test_load_use();
    load_use(4'd5, 1, "load_use_bubble");
    load_use(4'd0, 0, "load_r0_no_bubble");
  endtask

  task automatic test_stall();
    int s;
    exp_t e;
    out_ready = 1'b0;
    send(mk(OP_STW, 3, 1, 2, 15'd8), 32'h300, s);
    e        = model(mk(OP_STW, 3, 1, 2, 15'd8), 32'h300);
    in_valid = 1'b1;
    instr    = mk(OP_ADD, 9, 1, 2, 0);
    pc_in    = 32'h304;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || rd !== e.rd || imm !== e.imm ||
          pc_out !== e.pc || ctrl.mem_rw !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold c%0d got=v%b r%b rd%h imm%h pc%h required=v1 r0 rd%h imm%h pc%h",
                 c, out_valid, in_ready, rd, imm, pc_out, e.rd, e.imm, e.pc);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL stall_release got=%b required=1", in_ready);
    end else begin
      expQ.push_back(model(instr, pc_in));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle(2);
  endtask

  task automatic test_flush();
    int s;
    out_ready = 1'b0;
    send(mk(OP_BLT, 0, 1, 2, 15'h10), 32'h400, s);
    in_valid = 1'b1;
    instr    = mk(OP_SUB, 8, 1, 2, 0);
    pc_in    = 32'h404;
    flush    = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL flush_in_ready got=%b required=0", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL flush_squash got=%b required=0", out_valid);
    end
    if (expQ.size() > 0) void'(expQ.pop_back());
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(mk(OP_XOR, 10, 3, 4, 0), 32'h408, s);
    idle(2);
  endtask

  task automatic test_decode_table();
    int s;
    logic [31:0] prog[$];
    out_ready = 1'b1;
    send(mk(32'h1F, 1, 2, 3, 15'd5), 32'h500, s);
    tests++;
    if (illegal !== 1'b1 || ctrl !== '0) begin
      failures++; $display("FAIL illegal_op got=ill%b ctrl%h required=ill1 ctrl0", illegal, ctrl);
    end
    send(mk(OP_MOV, 7, 2, 5, 0), 32'h504, s);
    tests++;
    if (rs2 !== 4'd0 || ctrl.alu_op !== ALU_ORR || ctrl.reg_wr_en !== 1'b1) begin
      failures++; $display("FAIL mov_rs2 got=rs2 %h alu %0d required=rs2 0 alu %0d", rs2, ctrl.alu_op, ALU_ORR);
    end
    prog = '{mk(OP_ORR, 1, 2, 3, 0), mk(OP_XOR, 2, 3, 4, 0), mk(OP_SUB, 3, 4, 5, 0),
             mk(OP_AND, 4, 5, 6, 0), mk(OP_NOR, 5, 6, 7, 0), mk(OP_LSL, 6, 7, 8, 0),
             mk(OP_LSR, 7, 8, 9, 0), mk(OP_SUBI, 8, 9, 0, 15'd5), mk(OP_LDB, 11, 1, 0, 15'd3),
             mk(OP_STB, 12, 1, 2, 15'd3), mk(OP_BNE, 0, 1, 2, 15'h7FF0), mk(OP_BST, 0, 3, 4, 15'd2),
             mk(OP_NOP, 0, 0, 0, 0), mk(OP_LDW, 0, 2, 0, 15'h4000)};
    foreach (prog[i]) send(prog[i], 32'h600 + 32'(i) * 4, s);
    idle(3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_stall();
    test_flush();
    test_decode_table();
    tests++;
    if (expQ.size() != 0) begin
      failures++; $display("FAIL sb_drain got=%0d pending required=0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered, parametrised decode stage between fetch and execute; the next generation of the combinational opcode-to-control decoder. Decodes opcode, register indices and sign-extended immediate into a fully defined control bundle held in an output pipeline register. Valid/ready handshakes on both sides. Detects load-use hazards (inserts one bubble), supports branch flush and flags illegal opcodes.

Parameters:
INSTR_LEN, 32, instruction width in bits
XLEN, 32, datapath width; immediate sign-extended to this
OPCODE_SIZE, 5, opcode field width at instr[INSTR_LEN-1 -: OPCODE_SIZE]
REG_ADDR_W, 4, register index width; rd, rs1, rs2 follow the opcode in that order, MSB-first
IMM_W, 15, immediate field width, instr[IMM_W-1:0]

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous squash from branch resolution
in_valid  in  1  fetch offers instr
in_ready  out  1  stage accepts instr this cycle
instr  in  INSTR_LEN  instruction word
pc_in  in  XLEN  PC of instr
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
ctrl  out  control_t  control bundle (reg_wr_en, mem_en, mem_rw, sel_valb, sel_wrdata, sel_destreg, is_branch, alu_op)
rd, rs1, rs2  out  REG_ADDR_W each  register indices
imm  out  XLEN  sign-extended immediate
pc_out  out  XLEN  registered pc_in
illegal  out  1  opcode not in table; ctrl is NOP

Behaviour:
- Reset: out_valid=0, ctrl all-zero (alu_op=ALU_ADD), rd/rs1/rs2/imm/pc_out/illegal=0. Reset mid-transfer drops all contents.
- Latency: 1 cycle from accepted input to out_valid. Throughput 1/cycle with no hazard.
- Every ctrl field is assigned for every opcode; no inferred latches. Fields not listed below are 0.
- R-type ADD, SUB, AND, ORR, NOR, XOR, LSL, LSR: reg_wr_en=1; alu_op as named.
- ADDI/SUBI: reg_wr_en=1, sel_valb=1, sel_destreg=1; alu ADD/SUB.
- LDW/LDB: reg_wr_en, mem_en, sel_valb, sel_wrdata, sel_destreg=1; mem_rw=0; alu ADD.
- STW/STB: mem_en=1, mem_rw=1, sel_valb=1, sel_destreg=1; alu ADD.
- BNE/BST: is_branch=1, alu XOR. BLT: is_branch=1, alu ALU_LT.
- MOV: reg_wr_en=1, alu ORR; rs2 output forced to 0 (r0 reads zero).
- NOP: all-zero. Unknown opcode: all-zero plus illegal=1.
- Base in_ready = (!out_valid || out_ready) && !hazard && !flush. Output register loads on in_valid && in_ready. Otherwise it clears out_valid when out_ready, or holds when stalled.
- Hazard: out_valid, the held bundle is a load, its rd != 0, and the incoming instr reads rs1==rd or (uses rs2 and rs2==rd). Stores and R-type use rs2; I-type and loads do not.
- On hazard: in_ready=0. Once the load transfers, out_valid=0 for one cycle (bubble). The dependent instruction is then accepted, giving exactly one bubble.
- Flush: highest priority. Next cycle out_valid=0 and the input that cycle is not accepted. Flush together with out_ready: the current bundle is still considered transferred.
- Output fields are stable while out_valid && !out_ready.

Optional Feature:
DECODE_SKID_EN. Defined: adds a 1-entry skid buffer, and in_ready becomes a registered value (= !skid_full), with no combinational path from out_ready. An input arriving while the output is stalled is captured in the skid and drained first. Hazard and flush also apply to the skid entry, and flush empties it. Undefined: combinational in_ready as above, no skid storage.

Decomposition:
- Shared package / constants.svh: control_t, OP_* opcode constants, ALU_* constants including ALU_LT, ALU_OP_SIZE, and field-position localparams derived from the parameters.
- Sub-module ctrl_decode: purely combinational opcode -> {control_t, illegal, uses_rs2}. decode_stage instantiates it and owns the registers, handshake, hazard and flush logic.

Test Plan:
- Reset asserted mid-stream with out_valid=1 -> out_valid=0 and ctrl=0 immediately; first instr after release appears 1 cycle after acceptance.
- Back-to-back ADD r3,r1,r2 then ADDI r4,r3,-1 with out_ready=1 -> two consecutive valid cycles; ADDI gives imm=32'hFFFF_FFFF and sel_valb=1.
- LDW r5,[r1+4] followed by ADD r6,r5,r2 -> exactly one out_valid=0 bubble between them. With LDW r0 as the load -> no bubble.
- out_ready=0 for 3 cycles while holding STW -> outputs stable, in_ready=0; STW accepted on the cycle out_ready rises.
- flush pulsed while BLT is held and in_valid=1 -> next cycle out_valid=0 and the offered instr is not consumed.
- Unknown opcode 5'h1F -> illegal=1, all ctrl fields 0. ORR/XOR -> reg_wr_en=1. MOV r7,r2 -> rs2=0, alu ORR.
